// File: rtl/cmpcnt_sched.sv
// Round-robin scheduler for the shared counter/comparator: grants one requester,
// drives the compare word and count enable for a bounded run, and returns hit/count.
module cmpcnt_sched #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned CW     = 17,
    parameter int unsigned BW     = 16,
    parameter int unsigned SETTLE = 1
) (
    input  logic                CK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    REQ_VALID,
    output logic [N_REQ-1:0]    REQ_READY,
    input  logic [N_REQ*CW-1:0] REQ_CMP,
    input  logic [N_REQ*BW-1:0] REQ_BUDGET,
    output logic [CW-1:0]       C_OUT,
    output logic                P_OUT,
    input  logic                Z_IN,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [1:0]          RES_ID,
    output logic                RES_HIT,
    output logic [BW-1:0]       RES_COUNT,
    output logic                BUSY
);

    localparam int unsigned IW = 2;
    localparam int unsigned SW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic            found;
    logic            grant;
    logic [CW-1:0]   win_cmp;
    logic [BW-1:0]   win_bud;
    logic [BW-1:0]   bud_q;
    logic [BW-1:0]   cnt_inc;
    logic [SW-1:0]   settle_q;
    logic [IW-1:0]   ptr_nxt;

    // Round-robin search: first valid at or above the pointer, else lowest valid (wrap)
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && REQ_VALID[i] && (IW'(i) >= ptr)) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && REQ_VALID[i]) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_cmp = '0;
        win_bud = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (IW'(i) == winner) begin
                win_cmp = REQ_CMP[i*int'(CW) +: CW];
                win_bud = REQ_BUDGET[i*int'(BW) +: BW];
            end
        end
    end

    assign grant   = (state == IDLE) && found && !RST;
    assign cnt_inc = RES_COUNT + BW'(1);
    assign ptr_nxt = ((32'(winner) + 32'd1) >= N_REQ) ? '0 : winner + IW'(1);

    // State register
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (grant) state_n = SETUP;
            SETUP: if (settle_q == SW'(SETTLE - 1)) state_n = (bud_q == '0) ? DONE : RUN;
            RUN:   if (Z_IN || (cnt_inc == bud_q)) state_n = DONE;
            DONE:  if (RES_READY) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Combinational accept, only while idle
    always_comb begin
        REQ_READY = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant && (IW'(i) == winner)) begin
                REQ_READY[i] = 1'b1;
            end
        end
    end

    // Registered datapath and status outputs
    always_ff @(posedge CK) begin
        if (RST) begin
            ptr       <= '0;
            C_OUT     <= '0;
            P_OUT     <= 1'b0;
            RES_VALID <= 1'b0;
            RES_ID    <= '0;
            RES_HIT   <= 1'b0;
            RES_COUNT <= '0;
            BUSY      <= 1'b0;
            bud_q     <= '0;
            settle_q  <= '0;
        end else begin
            P_OUT     <= (state_n == RUN);
            RES_VALID <= (state_n == DONE);
            BUSY      <= (state_n != IDLE);
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        C_OUT     <= win_cmp;
                        bud_q     <= win_bud;
                        RES_ID    <= winner;
                        ptr       <= ptr_nxt;
                        RES_COUNT <= '0;
                        RES_HIT   <= 1'b0;
                        settle_q  <= '0;
                    end
                end
                SETUP: settle_q <= settle_q + SW'(1);
                RUN: begin
                    if (RES_COUNT != '1) RES_COUNT <= cnt_inc;
                    if (Z_IN) RES_HIT <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
